// File: rtl/triangle_list_reader.sv
// Triangle source for the projection stage: streams vertex triples from a
// synchronous-read memory, keeps one triangle prefetched and serves pops.
module triangle_list_reader #(
  parameter int WI = 8,
  parameter int WF = 8,
  parameter int AW = 10
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             list_start_i,
  input  logic [AW:0]                      tri_count_i,
  input  logic                             list_r_i,
  output logic                             mem_rden_o,
  output logic [AW+1:0]                    mem_addr_o,
  input  logic [2:0][WI+WF-1:0]            mem_rdata_i,
  output logic [2:0][2:0][WI+WF-1:0]       orig_triangle_o,
  output logic                             list_ready_o,
  output logic                             list_read_done_o,
  output logic                             underrun_o
);

  typedef enum logic [1:0] {IDLE, FETCH, WAITDATA, HOLD} state_t;

  state_t                        state_q, state_d;
  logic [AW:0]                   fetch_left_q, fetch_left_d;
  logic [AW:0]                   pop_left_q, pop_left_d;
  logic [AW+1:0]                 vaddr_q, vaddr_d;
  logic [1:0]                    vsel_q, vsel_d;
  logic [1:0]                    rcnt_q, rcnt_d;
  logic [2:0][2:0][WI+WF-1:0]    pf_tri_q, pf_tri_d;
  logic                          pf_valid_q, pf_valid_d;
  logic [2:0][2:0][WI+WF-1:0]    orig_q, orig_d;
  logic                          ready_q, ready_d;
  logic                          underrun_q, underrun_d;
  logic                          pop_d_q;
  logic                          gen_q, gen_d;
  logic                          rd_pend_q, rd_gen_q;

  logic pop_ok, pop_bad, rd_ret;

  assign mem_rden_o       = (state_q == FETCH);
  assign mem_addr_o       = vaddr_q;
  assign orig_triangle_o  = orig_q;
  assign list_ready_o     = ready_q;
  assign underrun_o       = underrun_q;
  // Held low in the cycle after the final pop so the projector's re-check still sees work.
  assign list_read_done_o = ready_q & (pop_left_q == '0) & ~pop_d_q;

  assign pop_ok  = list_r_i & (pop_left_q != '0) & pf_valid_q;
  assign pop_bad = list_r_i & (pop_left_q != '0) & ~pf_valid_q;
  // Reads issued before the latest restart carry the old generation and are dropped.
  assign rd_ret  = rd_pend_q & (rd_gen_q == gen_q);

  always_comb begin
    state_d      = state_q;
    fetch_left_d = fetch_left_q;
    pop_left_d   = pop_left_q;
    vaddr_d      = vaddr_q;
    vsel_d       = vsel_q;
    rcnt_d       = rcnt_q;
    pf_tri_d     = pf_tri_q;
    pf_valid_d   = pf_valid_q;
    orig_d       = orig_q;
    ready_d      = ready_q;
    underrun_d   = underrun_q;
    gen_d        = gen_q;

    if (rd_ret) begin
      pf_tri_d[vsel_q] = mem_rdata_i;
      vsel_d           = (vsel_q == 2'd2) ? 2'd0 : vsel_q + 2'd1;
    end

    unique case (state_q)
      FETCH: begin
        vaddr_d = vaddr_q + (AW+2)'(1);
        rcnt_d  = rcnt_q + 2'd1;
        if (rcnt_q == 2'd2) begin
          rcnt_d       = 2'd0;
          fetch_left_d = fetch_left_q - (AW+1)'(1);
          state_d      = WAITDATA;
        end
      end
      WAITDATA: begin
        if (rd_ret && vsel_q == 2'd2) begin
          pf_valid_d = 1'b1;
          ready_d    = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if ((!pf_valid_q || pop_ok) && fetch_left_q != '0) state_d = FETCH;
      end
      default: ;
    endcase

    if (pop_ok) begin
      orig_d     = pf_tri_q;
      pf_valid_d = 1'b0;
      pop_left_d = pop_left_q - (AW+1)'(1);
    end
    if (pop_bad) underrun_d = 1'b1;

    if (list_start_i) begin
      fetch_left_d = tri_count_i;
      pop_left_d   = tri_count_i;
      vaddr_d      = '0;
      vsel_d       = 2'd0;
      rcnt_d       = 2'd0;
      pf_valid_d   = 1'b0;
      orig_d       = orig_q;
      ready_d      = (tri_count_i == '0);
      underrun_d   = 1'b0;
      gen_d        = ~gen_q;
      state_d      = (tri_count_i == '0) ? HOLD : FETCH;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      fetch_left_q <= '0;
      pop_left_q   <= '0;
      vaddr_q      <= '0;
      vsel_q       <= '0;
      rcnt_q       <= '0;
      pf_tri_q     <= '0;
      pf_valid_q   <= 1'b0;
      orig_q       <= '0;
      ready_q      <= 1'b0;
      underrun_q   <= 1'b0;
      pop_d_q      <= 1'b0;
      gen_q        <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_gen_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_left_q <= fetch_left_d;
      pop_left_q   <= pop_left_d;
      vaddr_q      <= vaddr_d;
      vsel_q       <= vsel_d;
      rcnt_q       <= rcnt_d;
      pf_tri_q     <= pf_tri_d;
      pf_valid_q   <= pf_valid_d;
      orig_q       <= orig_d;
      ready_q      <= ready_d;
      underrun_q   <= underrun_d;
      pop_d_q      <= list_r_i;
      gen_q        <= gen_d;
      rd_pend_q    <= mem_rden_o;
      rd_gen_q     <= gen_q;
    end
  end

endmodule

// File: tb/tb_triangle_list_reader.sv
// Directed bench for triangle_list_reader: default-size instance plus a
// small AW=2 instance for the maximum-count pass.
module tb_triangle_list_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic                  list_start, list_r;
  logic [10:0]           tri_count;
  logic                  mem_rden;
  logic [11:0]           mem_addr;
  logic [2:0][15:0]      mem_rdata;
  logic [2:0][2:0][15:0] orig;
  logic                  ready, done, underrun;

  logic                  s_list_start, s_list_r;
  logic [2:0]            s_tri_count;
  logic                  s_mem_rden;
  logic [3:0]            s_mem_addr;
  logic [2:0][15:0]      s_mem_rdata;
  logic [2:0][2:0][15:0] s_orig;
  logic                  s_ready, s_done, s_underrun;

  int nvec = 0;
  int nmis = 0;
  int s_nreads = 0;
  logic [3:0] s_last_addr = '0;

  triangle_list_reader dut (
    .clk_i(clk), .reset_i(rst), .list_start_i(list_start), .tri_count_i(tri_count),
    .list_r_i(list_r), .mem_rden_o(mem_rden), .mem_addr_o(mem_addr),
    .mem_rdata_i(mem_rdata), .orig_triangle_o(orig), .list_ready_o(ready),
    .list_read_done_o(done), .underrun_o(underrun));

  triangle_list_reader #(.AW(2)) dut_s (
    .clk_i(clk), .reset_i(rst), .list_start_i(s_list_start), .tri_count_i(s_tri_count),
    .list_r_i(s_list_r), .mem_rden_o(s_mem_rden), .mem_addr_o(s_mem_addr),
    .mem_rdata_i(s_mem_rdata), .orig_triangle_o(s_orig), .list_ready_o(s_ready),
    .list_read_done_o(s_done), .underrun_o(s_underrun));

  function automatic logic [2:0][15:0] vtx(int k);
    logic [2:0][15:0] r;
    r[0] = 16'(k);
    r[1] = 16'(k + 'h100);
    r[2] = 16'(k + 'h200);
    return r;
  endfunction

  function automatic logic [2:0][2:0][15:0] tri_exp(int t);
    logic [2:0][2:0][15:0] r;
    for (int v = 0; v < 3; v++) r[v] = vtx(3*t + v);
    return r;
  endfunction

  // Synchronous-read vertex memories.
  always @(posedge clk) begin
    if (mem_rden) mem_rdata <= vtx(int'(mem_addr));
    if (s_mem_rden) begin
      s_mem_rdata <= vtx(int'(s_mem_addr));
      s_last_addr <= s_mem_addr;
      s_nreads    <= s_nreads + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic seen;
    if ({mem_rden, mem_addr, ready, done, underrun} !== '0 || orig !== '0) begin
      nmis++;
      $display("FAIL reset_state outputs rden=%b addr=%0d rdy=%b done=%b und=%b orig=%h, need all 0",
               mem_rden, mem_addr, ready, done, underrun, orig);
    end
    nvec++;
    rst = 1'b0;
    seen = 1'b0;
    repeat (5) begin step(); seen |= mem_rden; end
    if (seen !== 1'b0) begin nmis++; $display("FAIL reset_idle rden seen=%b need 0", seen); end
    nvec++;
    // Pass with one pop, then reset in the middle of the refill fetch.
    tri_count = 11'd2; list_start = 1'b1; step(); list_start = 1'b0;
    repeat (4) step();
    list_r = 1'b1; step(); list_r = 1'b0;
    if (orig !== tri_exp(0) || mem_rden !== 1'b1) begin
      nmis++; $display("FAIL reset_pre orig=%h rden=%b need %h / 1", orig, mem_rden, tri_exp(0));
    end
    nvec++;
    #3 rst = 1'b1;
    #1;
    if ({mem_rden, mem_addr, ready, done, underrun} !== '0 || orig !== '0) begin
      nmis++;
      $display("FAIL reset_async outputs rden=%b addr=%0d rdy=%b done=%b und=%b orig=%h, need all 0",
               mem_rden, mem_addr, ready, done, underrun, orig);
    end
    nvec++;
    rst = 1'b0;
    seen = 1'b0;
    repeat (5) begin step(); seen |= mem_rden; end
    if (seen !== 1'b0) begin nmis++; $display("FAIL reset_after rden seen=%b need 0", seen); end
    nvec++;
  endtask

  task automatic test_two_tri();
    tri_count = 11'd2; list_start = 1'b1; step(); list_start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (mem_rden !== 1'b1 || mem_addr !== 12'(c-1)) begin
        nmis++; $display("FAIL two_read%0d rden=%b addr=%0d need 1 / %0d", c, mem_rden, mem_addr, c-1);
      end
      nvec++;
      step();
    end
    if (mem_rden !== 1'b0 || ready !== 1'b0) begin
      nmis++; $display("FAIL two_cyc4 rden=%b rdy=%b need 0 / 0", mem_rden, ready);
    end
    nvec++;
    step();
    if (ready !== 1'b1 || done !== 1'b0) begin
      nmis++; $display("FAIL two_ready rdy=%b done=%b need 1 / 0", ready, done);
    end
    nvec++;
    step();
    list_r = 1'b1; step(); list_r = 1'b0;
    if (orig !== tri_exp(0) || done !== 1'b0) begin
      nmis++; $display("FAIL two_pop0 orig=%h done=%b need %h / 0", orig, done, tri_exp(0));
    end
    nvec++;
    repeat (7) step();
    list_r = 1'b1; step(); list_r = 1'b0;
    if (orig !== tri_exp(1) || done !== 1'b0) begin
      nmis++; $display("FAIL two_pop1 orig=%h done=%b need %h / 0", orig, done, tri_exp(1));
    end
    nvec++;
    step();
    if (done !== 1'b1) begin nmis++; $display("FAIL two_done_next done=%b need 1", done); end
    nvec++;
    repeat (6) step();
    if (done !== 1'b1 || underrun !== 1'b0 || orig !== tri_exp(1)) begin
      nmis++; $display("FAIL two_take3 done=%b und=%b orig=%h need 1 / 0 / %h", done, underrun, orig, tri_exp(1));
    end
    nvec++;
  endtask

  task automatic test_empty();
    logic seen;
    tri_count = 11'd0; list_start = 1'b1; step(); list_start = 1'b0;
    if (ready !== 1'b1 || done !== 1'b1) begin
      nmis++; $display("FAIL empty_cyc1 rdy=%b done=%b need 1 / 1", ready, done);
    end
    nvec++;
    seen = mem_rden;
    repeat (5) begin step(); seen |= mem_rden; end
    if (seen !== 1'b0 || done !== 1'b1) begin
      nmis++; $display("FAIL empty_hold rden seen=%b done=%b need 0 / 1", seen, done);
    end
    nvec++;
  endtask

  task automatic test_underrun();
    tri_count = 11'd3; list_start = 1'b1; step(); list_start = 1'b0;
    repeat (4) step();
    list_r = 1'b1; step(); list_r = 1'b0;
    if (orig !== tri_exp(0) || underrun !== 1'b0) begin
      nmis++; $display("FAIL und_pop0 orig=%h und=%b need %h / 0", orig, underrun, tri_exp(0));
    end
    nvec++;
    step();
    list_r = 1'b1; step(); list_r = 1'b0;
    if (underrun !== 1'b1 || orig !== tri_exp(0)) begin
      nmis++; $display("FAIL und_flag und=%b orig=%h need 1 / %h", underrun, orig, tri_exp(0));
    end
    nvec++;
    repeat (5) step();
    list_r = 1'b1; step(); list_r = 1'b0;
    if (orig !== tri_exp(1)) begin nmis++; $display("FAIL und_pop1 orig=%h need %h", orig, tri_exp(1)); end
    nvec++;
    repeat (7) step();
    if (done !== 1'b0) begin nmis++; $display("FAIL und_left done=%b need 0", done); end
    nvec++;
    list_r = 1'b1; step(); list_r = 1'b0;
    if (orig !== tri_exp(2)) begin nmis++; $display("FAIL und_pop2 orig=%h need %h", orig, tri_exp(2)); end
    nvec++;
    step();
    if (done !== 1'b1 || underrun !== 1'b1) begin
      nmis++; $display("FAIL und_end done=%b und=%b need 1 / 1", done, underrun);
    end
    nvec++;
  endtask

  task automatic test_restart();
    tri_count = 11'd2; list_start = 1'b1; step(); list_start = 1'b0;
    step();
    if (mem_rden !== 1'b1 || mem_addr !== 12'd1) begin
      nmis++; $display("FAIL rst_pre rden=%b addr=%0d need 1 / 1", mem_rden, mem_addr);
    end
    nvec++;
    tri_count = 11'd1; list_start = 1'b1; step(); list_start = 1'b0;
    if (underrun !== 1'b0) begin nmis++; $display("FAIL rst_und_clr und=%b need 0", underrun); end
    nvec++;
    for (int c = 0; c < 3; c++) begin
      if (mem_rden !== 1'b1 || mem_addr !== 12'(c)) begin
        nmis++; $display("FAIL rst_read%0d rden=%b addr=%0d need 1 / %0d", c, mem_rden, mem_addr, c);
      end
      nvec++;
      step();
    end
    if (ready !== 1'b0 || mem_rden !== 1'b0) begin
      nmis++; $display("FAIL rst_early rdy=%b rden=%b need 0 / 0", ready, mem_rden);
    end
    nvec++;
    step();
    if (ready !== 1'b1) begin nmis++; $display("FAIL rst_ready rdy=%b need 1", ready); end
    nvec++;
    list_r = 1'b1; step(); list_r = 1'b0;
    if (orig !== tri_exp(0)) begin nmis++; $display("FAIL rst_data orig=%h need %h", orig, tri_exp(0)); end
    nvec++;
    step();
    if (done !== 1'b1) begin nmis++; $display("FAIL rst_done done=%b need 1", done); end
    nvec++;
  endtask

  task automatic test_max_count();
    s_tri_count = 3'd4; s_list_start = 1'b1; step(); s_list_start = 1'b0;
    repeat (4) step();
    if (s_ready !== 1'b1) begin nmis++; $display("FAIL max_ready rdy=%b need 1", s_ready); end
    nvec++;
    for (int t = 0; t < 4; t++) begin
      if (s_done !== 1'b0) begin nmis++; $display("FAIL max_done_early%0d done=%b need 0", t, s_done); end
      nvec++;
      s_list_r = 1'b1; step(); s_list_r = 1'b0;
      if (s_orig !== tri_exp(t)) begin
        nmis++; $display("FAIL max_pop%0d orig=%h need %h", t, s_orig, tri_exp(t));
      end
      nvec++;
      repeat (6) step();
    end
    if (s_done !== 1'b1 || s_underrun !== 1'b0) begin
      nmis++; $display("FAIL max_end done=%b und=%b need 1 / 0", s_done, s_underrun);
    end
    nvec++;
    if (s_last_addr !== 4'd11 || s_nreads !== 12) begin
      nmis++; $display("FAIL max_addr last=%0d reads=%0d need 11 / 12", s_last_addr, s_nreads);
    end
    nvec++;
  endtask

  initial begin
    rst = 1'b1;
    list_start = 1'b0; list_r = 1'b0; tri_count = '0;
    s_list_start = 1'b0; s_list_r = 1'b0; s_tri_count = '0;
    #2;
    test_reset();
    test_two_tri();
    test_empty();
    test_underrun();
    test_restart();
    test_max_count();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
